// File: rtl/serial_twos_complementer.sv
// Bit-serial two's complement negator: accepts a parallel operand, emits the negated
// value LSB first over WIDTH cycles, then holds the parallel result until consumed.
module serial_twos_complementer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] In,
  input  logic             In_valid,
  output logic             In_ready,
  output logic [WIDTH-1:0] Out,
  output logic             Out_valid,
  input  logic             Out_ready,
  output logic             Serial_out,
  output logic             Serial_valid,
  output logic             Overflow,
  output logic             Zero
);

  localparam int unsigned     CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e r_state, w_state_d;

  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_out;
  logic [CntW-1:0]  r_cnt;
  logic             r_carry;
  logic             r_ovf;
  logic             r_zero;

  logic             w_bit;
  logic             w_serial;
  logic [WIDTH-1:0] w_result;
  logic             w_accept;
  logic             w_shift;
  logic             w_last;

  // Invert every bit above the first set bit; bits up to and including it pass through.
  assign w_bit    = r_shift[0];
  assign w_serial = r_carry ? ~w_bit : w_bit;
  assign w_result = {w_serial, r_acc[WIDTH-1:1]};
  assign w_accept = (r_state == StIdle) && In_valid;
  assign w_shift  = (r_state == StShift);
  assign w_last   = w_shift && (r_cnt == LastCnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (In_valid)  w_state_d = StShift;
      StShift: if (w_last)    w_state_d = StDone;
      StDone:  if (Out_ready) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_acc   <= '0;
      r_out   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else if (w_accept) begin
      r_shift <= In;
      r_cnt   <= '0;
      r_carry <= 1'b0;
    end else if (w_shift) begin
      r_shift <= r_shift >> 1;
      r_carry <= r_carry | w_bit;
      r_acc   <= w_result;
      if (!w_last) begin
        r_cnt <= r_cnt + CntW'(1);
      end
      // Out only moves once the full result is assembled.
      if (w_last) begin
        r_out  <= w_result;
        r_ovf  <= (w_result == MinNeg);
        r_zero <= (w_result == '0);
      end
    end
  end

  always_comb begin
    In_ready     = (r_state == StIdle);
    Out_valid    = (r_state == StDone);
    Serial_valid = w_shift;
    Serial_out   = w_shift ? w_serial : 1'b0;
    Overflow     = (r_state == StDone) ? r_ovf : 1'b0;
    Zero         = (r_state == StDone) ? r_zero : 1'b0;
    Out          = r_out;
  end

endmodule
